// File: rtl/logic_unit_pipe_if.sv
// rtl/logic_unit_pipe_if.sv - handshake/operand/result bundle for logic_unit_pipe
// Purpose: groups the input handshake and operands, the output handshake and
// the registered result/status signals of logic_unit_pipe.
// Signals: in_valid/in_ready, a, b, op, acc, acc_clr (input side);
//          out_valid/out_ready, y, zero, parity, txn_cnt (output side).
// master: the producer/consumer environment. slave: the logic unit.
interface logic_unit_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             acc;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             parity;
    logic [CNT_W-1:0] txn_cnt;

    modport master (
        output in_valid, a, b, op, acc, acc_clr, out_ready,
        input  in_ready, out_valid, y, zero, parity, txn_cnt
    );

    modport slave (
        input  in_valid, a, b, op, acc, acc_clr, out_ready,
        output in_ready, out_valid, y, zero, parity, txn_cnt
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - registered bitwise logic unit with handshake and accumulator
// Purpose: one registered bitwise result per accepted transaction, with an
// optional accumulator feeding operand A, zero/parity flags and a saturating
// transaction counter.
// Ports: clk (rising edge), rst_n (synchronous, active low),
//        bus (logic_unit_pipe_if.slave): in_valid/in_ready, a, b, op, acc,
//        acc_clr, out_valid/out_ready, y, zero, parity, txn_cnt.
module logic_unit_pipe #(
    parameter int WIDTH  = 8,
    parameter int ACC_EN = 1,
    parameter int CNT_W  = 16
) (
    input logic              clk,
    input logic              rst_n,
    logic_unit_pipe_if.slave bus
);
    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XNOR = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;

    logic             out_valid_q;
    logic [WIDTH-1:0] y_q;
    logic             zero_q;
    logic             parity_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] acc_q;

    logic             in_ready;
    logic             accept;
    logic             drain;
    logic             use_acc;
    logic             clr_acc;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] result;

    // A stalled result blocks new work; a draining one makes room this cycle.
    assign in_ready = rst_n && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign drain    = out_valid_q && bus.out_ready;

    assign use_acc  = (ACC_EN != 0) && bus.acc;
    assign clr_acc  = (ACC_EN != 0) && bus.acc_clr;
    // acc_clr zeroes the operand in the same cycle, so clear-and-use needs no bubble.
    assign op_a     = use_acc ? (bus.acc_clr ? '0 : acc_q) : bus.a;

    always_comb begin
        result = op_a;
        case (bus.op)
            OP_AND:  result = op_a & bus.b;
            OP_OR:   result = op_a | bus.b;
            OP_NAND: result = ~(op_a & bus.b);
            OP_NOR:  result = ~(op_a | bus.b);
            OP_XNOR: result = ~(op_a ^ bus.b);
            OP_XOR:  result = op_a ^ bus.b;
            OP_NOT:  result = ~op_a;
            default: result = op_a;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
            zero_q      <= 1'b1;
            parity_q    <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            y_q         <= result;
            zero_q      <= (result == '0);
            parity_q    <= ^result;
            acc_q       <= result;
            if (cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else begin
            if (drain) begin
                out_valid_q <= 1'b0;
            end
            if (clr_acc) begin
                acc_q <= '0;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.zero      = zero_q;
    assign bus.parity    = parity_q;
    assign bus.txn_cnt   = cnt_q;
endmodule
